// File: rtl/mem_port_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_mux_pkg
// Description : Shared state encoding and index-width helper for mem_port_mux.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_mux_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // A single requester still needs a one-bit index to keep vectors legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_mux_if
// Description : Requester, response and shared memory-port signals of mem_port_mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_mux_if #(
    parameter int N  = 4,
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_we;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_last;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;
    logic            err;

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_last,
        output req_ready, rsp_valid, rsp_data,
        output mem_req_valid, mem_addr, mem_we, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output err
    );

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_last,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_mux_resp_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_id_fifo
// Description : In-order FIFO of requester indices awaiting a memory response.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [WIDTH-1:0]      head
);
    localparam int c_PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses a push even if the head leaves in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == (c_PW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PW+1)'(1);
                2'b01:   r_count <= r_count - (c_PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_mux
// Description : Round-robin N:1 memory port mux with burst lock and in-order response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_mux
    import mem_port_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      rstn,
    mem_port_mux_if.slave  bus
);
    localparam int c_IW = idx_width(N);

    state_t          r_state;
    logic [c_IW-1:0] r_grant;
    logic [c_IW-1:0] r_last;
    logic            r_err;

    logic [c_IW-1:0] w_cand;
    logic [c_IW-1:0] w_rr_idx;
    logic            w_found;
    logic [c_IW-1:0] w_winner;
    logic            w_has_winner;
    logic            w_mem_req_valid;
    logic [N-1:0]    w_req_ready;
    logic            w_xfer;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_IW-1:0] w_head;
    logic            w_pop;
    logic [N-1:0]    w_rsp_valid;

    // Round-robin search starting just after the last requester served.
    always_comb begin
        w_cand   = '0;
        w_found  = 1'b0;
        w_rr_idx = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = c_IW'((int'(r_last) + k) % N);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_rr_idx = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    // Without a held grant and with nobody asking there is no winner at all.
    assign w_has_winner    = rstn && ((r_state == BURST) || w_found);
    assign w_winner        = (r_state == BURST) ? r_grant : w_rr_idx;
    assign w_mem_req_valid = w_has_winner && bus.req_valid[w_winner] && !w_fifo_full;
    assign w_xfer          = w_mem_req_valid && bus.mem_req_ready;

    always_comb begin
        w_req_ready = '0;
        if (w_has_winner) begin
            w_req_ready[w_winner] = bus.mem_req_ready && !w_fifo_full;
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.mem_req_valid = w_mem_req_valid;
    assign bus.mem_addr      = bus.req_addr[w_winner*AW +: AW];
    assign bus.mem_we        = bus.req_we[w_winner];
    assign bus.mem_wdata     = bus.req_wdata[w_winner*DW +: DW];

    assign w_pop = rstn && bus.mem_rsp_valid && !w_fifo_empty;

    always_comb begin
        w_rsp_valid = '0;
        if (w_pop) begin
            w_rsp_valid[w_head] = 1'b1;
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = bus.mem_rsp_data;
    assign bus.err       = r_err;

    resp_id_fifo #(
        .WIDTH (c_IW),
        .DEPTH (DEPTH)
    ) u_resp_id_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_xfer),
        .pop   (w_pop),
        .wdata (w_winner),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= c_IW'(N-1);
            r_err   <= 1'b0;
        end else begin
            if (bus.mem_rsp_valid && w_fifo_empty) begin
                r_err <= 1'b1;
            end
            if (w_xfer) begin
                case (r_state)
                    IDLE: begin
                        if (bus.req_last[w_winner]) begin
                            r_last <= w_winner;
                        end else begin
                            r_state <= BURST;
                            r_grant <= w_winner;
                        end
                    end
                    BURST: begin
                        if (bus.req_last[w_winner]) begin
                            r_state <= IDLE;
                            r_last  <= w_winner;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_mux
// Description : Self-checking bench for mem_port_mux: directed scenarios plus random traffic vs a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_mux;
    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_mux_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    mem_port_mux #(.N(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: who holds the lock (-1 = nobody), last served, queue of pending IDs.
    int m_owner;
    int m_last;
    int m_q[$];
    bit m_err;

    logic [N-1:0]  g_ready;
    logic [N-1:0]  g_rsp;
    logic [DW-1:0] g_rdata;
    logic          g_err;
    logic          g_xfer;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_q.delete();
        m_err   = 1'b0;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = $urandom;
            bus.req_wdata[i*DW +: DW] = {$urandom, $urandom};
            bus.req_we[i]             = $urandom_range(0, 1) == 1;
        end
        bus.mem_rsp_data = {$urandom, $urandom};
    endtask

    // Inputs are set at the falling edge; outputs are checked 2ns later, well before the rising edge.
    task automatic step();
        int           w;
        bit           hw;
        bit           full;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        bit           e_mv;
        #2;
        if (!rstn) model_reset();
        full = (m_q.size() == DEPTH);
        hw   = 1'b0;
        w    = 0;
        if (rstn) begin
            if (m_owner >= 0) begin
                hw = 1'b1;
                w  = m_owner;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!hw && bus.req_valid[c]) begin
                        hw = 1'b1;
                        w  = c;
                    end
                end
            end
        end
        e_ready = '0;
        if (hw && bus.mem_req_ready && !full) e_ready[w] = 1'b1;
        e_mv  = hw && bus.req_valid[w] && !full;
        e_rsp = '0;
        if (rstn && bus.mem_rsp_valid && m_q.size() > 0) e_rsp[m_q[0]] = 1'b1;

        chk("req_ready", 64'(bus.req_ready), 64'(e_ready));
        chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(e_mv));
        if (e_mv) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(bus.req_addr[w*AW +: AW]));
            chk("mem_we", 64'(bus.mem_we), 64'(bus.req_we[w]));
            chk("mem_wdata", bus.mem_wdata, bus.req_wdata[w*DW +: DW]);
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
        if (e_rsp != '0) chk("rsp_data", bus.rsp_data, bus.mem_rsp_data);
        chk("err", 64'(bus.err), 64'(m_err));

        g_ready = bus.req_ready;
        g_rsp   = bus.rsp_valid;
        g_rdata = bus.rsp_data;
        g_err   = bus.err;
        g_xfer  = bus.mem_req_valid && bus.mem_req_ready;

        if (rstn) begin
            if (bus.mem_rsp_valid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (e_mv && bus.mem_req_ready) begin
                m_q.push_back(w);
                if (bus.req_last[w]) begin
                    m_owner = -1;
                    m_last  = w;
                end else if (m_owner < 0) begin
                    m_owner = w;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.req_valid     = '0;
        bus.req_last      = '1;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        rand_payload();
    endtask

    task automatic do_reset();
        quiet();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic auto_rsp();
        bus.mem_rsp_valid = (m_q.size() > 0);
        rand_payload();
    endtask

    int n_acc;

    initial begin
        model_reset();
        quiet();
        rstn = 1'b0;
        step();
        chk("reset_mem_req_valid", 64'(g_xfer), 64'd0);
        chk("reset_req_ready", 64'(g_ready), 64'd0);
        chk("reset_err", 64'(g_err), 64'd0);
        rstn = 1'b1;
        step();
        chk("idle_req_ready", 64'(g_ready), 64'd0);

        // Round-robin of four single-beat requesters
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bus.mem_rsp_valid = (i >= 1);
            rand_payload();
            step();
            chk("rr_grant", 64'(g_ready), 64'(4'b0001 << (i % 4)));
        end

        // Burst lock holds through a valid gap
        do_reset();
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            auto_rsp();
            step();
            chk("burst_beat_early", 64'(g_ready & {N{g_xfer}}), 64'(4'b0010));
        end
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            auto_rsp();
            step();
            chk("burst_gap_hold", 64'(g_ready), 64'(4'b0010));
            chk("burst_gap_no_xfer", 64'(g_xfer), 64'd0);
        end
        bus.req_valid = 4'b0110;
        auto_rsp();
        step();
        chk("burst_beat3", 64'(g_ready & {N{g_xfer}}), 64'(4'b0010));
        bus.req_last = 4'b0110;
        auto_rsp();
        step();
        chk("burst_beat4", 64'(g_ready & {N{g_xfer}}), 64'(4'b0010));
        auto_rsp();
        step();
        chk("burst_next_r2", 64'(g_ready & {N{g_xfer}}), 64'(4'b0100));

        // FIFO full blocks acceptance, including on the pop cycle
        do_reset();
        bus.req_valid = 4'b0001;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            rand_payload();
            step();
            if (g_xfer) n_acc++;
        end
        chk("full_accepted", 64'(n_acc), 64'd4);
        chk("full_ready_low", 64'(g_ready), 64'd0);
        bus.mem_rsp_valid = 1'b1;
        step();
        chk("full_pop_cycle_ready", 64'(g_ready), 64'd0);
        chk("full_pop_rsp", 64'(g_rsp), 64'(4'b0001));
        bus.mem_rsp_valid = 1'b0;
        step();
        chk("full_after_pop_ready", 64'(g_ready), 64'(4'b0001));
        chk("full_after_pop_xfer", 64'(g_xfer), 64'd1);

        // Response routing follows accepted order
        do_reset();
        bus.req_valid = 4'b1000; step();
        bus.req_valid = 4'b0001; step();
        bus.req_valid = 4'b1000; step();
        bus.req_valid = 4'b0000;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = 64'hAAAA_0000_0000_000A; step();
        chk("route_a_valid", 64'(g_rsp), 64'(4'b1000));
        chk("route_a_data", g_rdata, 64'hAAAA_0000_0000_000A);
        bus.mem_rsp_data = 64'hBBBB_0000_0000_000B; step();
        chk("route_b_valid", 64'(g_rsp), 64'(4'b0001));
        chk("route_b_data", g_rdata, 64'hBBBB_0000_0000_000B);
        bus.mem_rsp_data = 64'hCCCC_0000_0000_000C; step();
        chk("route_c_valid", 64'(g_rsp), 64'(4'b1000));
        chk("route_c_data", g_rdata, 64'hCCCC_0000_0000_000C);
        bus.mem_rsp_valid = 1'b0;

        // Stray response sets a sticky error
        do_reset();
        bus.mem_rsp_valid = 1'b1;
        step();
        chk("stray_rsp_valid", 64'(g_rsp), 64'd0);
        bus.mem_rsp_valid = 1'b0;
        step();
        chk("err_set", 64'(g_err), 64'd1);
        step(); step(); step();
        chk("err_sticky", 64'(g_err), 64'd1);
        do_reset();
        step();
        chk("err_cleared", 64'(g_err), 64'd0);

        // Reset mid-burst abandons lock and outstanding IDs
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0000;
        step(); step();
        rstn = 1'b0;
        step();
        chk("midburst_reset_ready", 64'(g_ready), 64'd0);
        rstn = 1'b1;
        bus.req_valid     = 4'b0000;
        bus.mem_rsp_valid = 1'b1;
        step();
        chk("midburst_fifo_empty", 64'(g_rsp), 64'd0);
        bus.mem_rsp_valid = 1'b0;
        bus.req_valid     = 4'b0101;
        bus.req_last      = 4'b1111;
        step();
        chk("midburst_r0_wins", 64'(g_ready & {N{g_xfer}}), 64'(4'b0001));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid     = N'($urandom);
            bus.req_last      = N'($urandom) | N'($urandom);
            bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            bus.mem_rsp_valid = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                                 : ($urandom_range(0, 99) == 0);
            rand_payload();
            rstn = ($urandom_range(0, 299) != 0);
            step();
            rstn = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
